// File: rtl/riscuva_io_responder.sv
// Port-space responder for the RISCuva1 core: GPIO, one prescaled timer, and interrupt pend/mask/cause.
// Define IO_EXTIRQ_EN to build the external edge-interrupt source (pend[1]/mask[1]).
module riscuva_io_responder #(
  parameter logic [7:0] BASE     = 8'hE0,
  parameter int         PRESCALE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] portAddress,
  input  logic       portRead,
  input  logic       portWrite,
  input  logic [7:0] wrData,
  output logic [7:0] rdData,
  output logic       intReq,
  input  logic       intAck,
  input  logic [7:0] gpioIn,
  output logic [7:0] gpioOut,
  input  logic       extIrq
);

  localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);
`ifdef IO_EXTIRQ_EN
  localparam logic [1:0] IRQ_BITS = 2'b11;
`else
  localparam logic [1:0] IRQ_BITS = 2'b01;
`endif

  logic [7:0] gpio_out_q, gpio_out_d;
  logic [7:0] gpio_s1_q, gpio_s2_q;
  logic [7:0] reload_q, reload_d;
  logic [7:0] count_q, count_d;
  logic       en_q, en_d;
  logic       auto_q, auto_d;
  logic [7:0] presc_q, presc_d;
  logic [1:0] pend_q, pend_d;
  logic [1:0] mask_q, mask_d;
  logic [1:0] cause_q, cause_d;
  logic       ack_q;
  logic       int_req_q, int_req_d;

  logic       hit, wr_hit, count_wr, tick, expire, ext_edge;
  logic [2:0] offset;
  logic [1:0] w1c;

  // The CPU pulses portRead or portWrite for exactly one cycle per access; a
  // write lands at the edge that samples the strobe, a read is answered in the same cycle.
  assign hit      = (portAddress[7:3] == BASE[7:3]);
  assign offset   = portAddress[2:0];
  assign wr_hit   = portWrite && hit;
  assign count_wr = wr_hit && (offset == 3'd3);
  assign tick     = en_q && (presc_q == PRESC_LAST);
  // A same-cycle count write cancels the tick entirely, including its expiry.
  assign expire   = tick && !count_wr && (count_q == 8'd0);

  assign presc_d   = (!en_q || count_wr || tick) ? 8'd0 : presc_q + 8'd1;
  assign cause_d   = (intAck && !ack_q) ? (pend_q & mask_q) : cause_q;
  assign int_req_d = |(pend_q & mask_q);

`ifdef IO_EXTIRQ_EN
  logic ext_s1_q, ext_s2_q, ext_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_s1_q   <= 1'b0;
      ext_s2_q   <= 1'b0;
      ext_prev_q <= 1'b0;
    end else begin
      ext_s1_q   <= extIrq;
      ext_s2_q   <= ext_s1_q;
      ext_prev_q <= ext_s2_q;
    end
  end

  assign ext_edge = ext_s2_q && !ext_prev_q;
`else
  logic unused_ext;
  assign unused_ext = extIrq;
  assign ext_edge   = 1'b0;
`endif

  always_comb begin
    gpio_out_d = gpio_out_q;
    reload_d   = reload_q;
    count_d    = count_q;
    en_d       = en_q;
    auto_d     = auto_q;
    mask_d     = mask_q;
    w1c        = 2'b00;
    if (tick && !count_wr) begin
      if (count_q != 8'd0) count_d = count_q - 8'd1;
      else if (auto_q)     count_d = reload_q;
      else                 en_d    = 1'b0;
    end
    // Register writes come last so they override the timer's own updates.
    if (wr_hit) begin
      case (offset)
        3'd0: gpio_out_d = wrData;
        3'd2: reload_d   = wrData;
        3'd3: count_d    = wrData;
        3'd4: begin
          en_d   = wrData[0];
          auto_d = wrData[1];
        end
        3'd5: w1c    = wrData[1:0];
        3'd6: mask_d = wrData[1:0] & IRQ_BITS;
        default: ;
      endcase
    end
    pend_d = ((pend_q & ~w1c) | {ext_edge, expire}) & IRQ_BITS;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gpio_out_q <= 8'h00;
      gpio_s1_q  <= 8'h00;
      gpio_s2_q  <= 8'h00;
      reload_q   <= 8'h00;
      count_q    <= 8'h00;
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      presc_q    <= 8'h00;
      pend_q     <= 2'b00;
      mask_q     <= 2'b00;
      cause_q    <= 2'b00;
      ack_q      <= 1'b0;
      int_req_q  <= 1'b0;
    end else begin
      gpio_out_q <= gpio_out_d;
      gpio_s1_q  <= gpioIn;
      gpio_s2_q  <= gpio_s1_q;
      reload_q   <= reload_d;
      count_q    <= count_d;
      en_q       <= en_d;
      auto_q     <= auto_d;
      presc_q    <= presc_d;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      cause_q    <= cause_d;
      ack_q      <= intAck;
      int_req_q  <= int_req_d;
    end
  end

  always_comb begin
    rdData = 8'h00;
    if (portRead && hit) begin
      case (offset)
        3'd0: rdData = gpio_out_q;
        3'd1: rdData = gpio_s2_q;
        3'd2: rdData = reload_q;
        3'd3: rdData = count_q;
        3'd4: rdData = {6'b0, auto_q, en_q};
        3'd5: rdData = {6'b0, pend_q};
        3'd6: rdData = {6'b0, mask_q};
        3'd7: rdData = {6'b0, cause_q};
        default: rdData = 8'h00;
      endcase
    end
  end

  assign gpioOut = gpio_out_q;
  assign intReq  = int_req_q;

endmodule

// File: doc/riscuva_io_responder.md
# riscuva_io_responder

Responder end of the RISCuva1 I/O port bus and interrupt handshake. It decodes an 8-register window in the CPU port space and captures CPU writes. It drives read data back to the CPU and raises `intReq` from a timer and an optional external-edge source. The block sits beside the core and connects one-to-one to the core's `portAddress`/`portRead`/`portWrite`/`dataOut`/`dataIn`/`intReq`/`intAck` pins.

## Interface
- `BASE`, 8'hE0: window base address; low 3 bits must be 0; default sits in the direct-access page.
- `PRESCALE`, 16: clocks per timer tick; legal range 1..256.
- `clk`  in  1  single system clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `portAddress`  in  8  port address from the CPU.
- `portRead`  in  1  CPU read strobe; one cycle per access.
- `portWrite`  in  1  CPU write strobe; one cycle per access.
- `wrData`  in  8  write data; connects to the CPU `dataOut`.
- `rdData`  out  8  read data; connects to the CPU `dataIn`.
- `intReq`  out  1  interrupt request to the CPU; registered.
- `intAck`  in  1  CPU interrupt acknowledge; level, high from IRQ entry to RETI.
- `gpioIn`  in  8  asynchronous general-purpose inputs.
- `gpioOut`  out  8  registered general-purpose outputs.
- `extIrq`  in  1  asynchronous external interrupt line; used only with `IO_EXTIRQ_EN`.

## Operation
- Hit: `portAddress[7:3] == BASE[7:3]`. Offset is `portAddress[2:0]`. Misses are ignored.
- Register map (offset, access, function):
  - 0, RW, GPIO_OUT: drives `gpioOut`.
  - 1, R, GPIO_IN: `gpioIn` through a 2-flop synchronizer.
  - 2, RW, TMR_RELOAD.
  - 3, R/W, TMR_COUNT: a write loads the count and clears the prescaler.
  - 4, RW, TMR_CTRL: bit0 EN, bit1 AUTO; other bits read 0.
  - 5, R/W1C, IRQ_PEND: bit0 timer, bit1 external; other bits read 0.
  - 6, RW, IRQ_MASK: bits[1:0] only.
  - 7, R, IRQ_CAUSE: snapshot of `IRQ_PEND & IRQ_MASK`, taken on the `intAck` rising edge.
- Writes to read-only offsets (1, 7) are ignored.
- Reads have no side effects.
- `rdData` is combinational: the addressed register when `portRead` and hit, otherwise 8'h00.
- Prescaler:
  - Counts 0..PRESCALE-1 while EN=1.
  - A tick is generated when it wraps to 0.
  - Held at 0 while EN=0.
- Timer tick with count == 0:
  - Sets pend[0].
  - If AUTO=1: count <= reload.
  - If AUTO=0: EN cleared (one-shot).
- Timer tick with count != 0: count decrements by 1.
- Period is (reload+1)*PRESCALE clocks.
- `intReq` is registered as `|(IRQ_PEND & IRQ_MASK)`. It stays high until software clears the source by W1C or masking. The CPU ignores it while `intAck` is high.
- `intAck` rise is detected against a registered copy of `intAck`.
- Simultaneous events:
  - A set event beats W1C on the same pend bit.
  - A TMR_COUNT write beats a same-cycle tick.
  - A TMR_CTRL write beats the one-shot EN clear.
  - `portRead` and `portWrite` are never both asserted by the CPU. If both are asserted, the write executes and `rdData` still shows the pre-write value.

## Timing
- Reset (async assert):
  - All registers, synchronizers and the prescaler go to 0.
  - `gpioOut`=0 and `intReq`=0 immediately.
  - `rdData`=0 while `portRead` is low.
- Deassertion is sampled at the next rising `clk`.
- Write latency: a register updates at the edge that samples `portWrite`. `gpioOut` changes at that same edge.
- Read latency: 0 cycles. Data is valid in the `portRead` cycle, and the CPU captures it at the ending edge.
- GPIO_IN latency: 2 edges from a stable `gpioIn`.
- IRQ latency: pend set at edge N gives `intReq` high after edge N+1. A W1C at edge M gives `intReq` low after edge M+1.
- IRQ_CAUSE is written at the first edge where `intAck`=1 and the previous `intAck`=0.
- Reset mid-count aborts the timer. EN=0 after reset, so no spurious tick or interrupt follows.

## Configuration
- `IO_EXTIRQ_EN` defined:
  - `extIrq` passes through a 2-flop synchronizer and a rising-edge detector.
  - Each detected edge sets pend[1]. Edge latency is 3 edges.
- `IO_EXTIRQ_EN` undefined:
  - No synchronizer is built and `extIrq` is ignored; the port remains.
  - pend[1] and mask[1] read 0 and are not writable.

## Test plan
- Write 8'hA5 to 8'hE0 → `gpioOut`=8'hA5 after that edge. Read 8'hE0 → `rdData`=8'hA5 in the read cycle. Read 8'hD0 → 8'h00.
- `gpioIn`=8'h3C held → read 8'hE1 returns 8'h3C from the 3rd cycle; the first two cycles return the old value.
- PRESCALE=4: write reload=2, count=2, mask=1, ctrl=8'h03 → pend[0] sets every 12 clocks, and `intReq` rises 1 cycle after each pend set. With ctrl=8'h01 → one expiry, then EN reads 0.
- Timer pending with `intAck` 0→1 → IRQ_CAUSE=8'h01. Write 8'h01 to 8'hE5 → `intReq` low 1 cycle later.
- W1C of pend[0] in the same cycle as a timer expiry → pend[0] stays 1 and `intReq` stays high.
- `reset_n` pulsed low mid-count with `intReq` high → `intReq`, `gpioOut` and all registers read 0 immediately. With `IO_EXTIRQ_EN`, an `extIrq` rising edge after reset and mask=2 → pend=8'h02.
